alu_reservation_station: RTL and testbench
==========================================

# alu_reservation_station

- Reservation station for the ALU execution unit.
- Accepts renamed ALU ops from the issue stage and holds them until both source operands are available.
- Captures missing operands by snooping the common data bus (CDB), then dispatches one ready entry per cycle to the ALU over its valid/ack dispatch interface.

## Interface
- TAG_WIDTH, 6, width of physical/ROB tags on issue, dispatch and CDB.
- NUM_ENTRIES, 4, number of station entries (2..16).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- flush  in  1  synchronous squash of all entries.
- issue_valid  in  1  issue stage presents an op.
- issue_ready  out  1  station can accept; equals !full.
- issue_op  in  3  ALU opcode.
- issue_src1_rdy, issue_src2_rdy  in  1 each  operand value already valid.
- issue_src1_val, issue_src2_val  in  32 each  operand values (used when rdy=1).
- issue_src1_tag, issue_src2_tag  in  TAG_WIDTH each  producer tags (used when rdy=0).
- issue_dest_tag  in  TAG_WIDTH  result tag of this op.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_WIDTH  broadcast tag.
- cdb_data  in  32  broadcast value.
- dispatch_valid  out  1  a ready entry is offered to the ALU.
- dispatch_op  out  3  opcode of offered entry.
- dispatch_val1, dispatch_val2  out  32 each  operand values.
- dispatch_tag  out  TAG_WIDTH  dest tag of offered entry.
- dispatch_ack  in  1  ALU accepts the offered entry this cycle.
- full, empty  out  1 each  occupancy flags.
- count  out  $clog2(NUM_ENTRIES+1)  number of valid entries.

## Operation
- Entry state: valid, op, dest_tag, and per source: rdy, val, tag.
- **Allocation:** when issue_valid && issue_ready, the op is written into the lowest-index free entry.
- **Issue-time bypass:** for a source with rdy=0, if cdb_valid and cdb_tag equals the source tag in the same cycle, the entry is written with rdy=1 and val=cdb_data.
- **Wakeup:** each cycle, every valid entry's non-ready source whose tag equals cdb_tag (with cdb_valid=1) sets rdy=1 and latches cdb_data. Both sources of one entry may wake on the same broadcast.
- **Select:** the lowest-index valid entry with both rdy=1 is offered on dispatch_*.
- **Dispatch outputs:** combinational from registered state. They are all-zero when dispatch_valid=0.
- **Re-selection:** the offered entry may change between cycles while unacknowledged. The ALU consumes whatever is presented in the cycle dispatch_ack=1.
- **Free:** on a clock edge with dispatch_valid && dispatch_ack, the selected entry's valid clears.
- **Flush:** highest priority. On the edge with flush=1, all valid bits clear, and any issue or ack that cycle is ignored. dispatch_valid is forced 0 while flush=1.
- **Reset (rst_n=0 at edge):** all valid, rdy and payload bits clear. Afterwards dispatch_valid=0, dispatch_* =0, issue_ready=1, full=0, empty=1, count=0.

## Timing
- Issue to dispatch: an op issued with both sources ready at edge N can be offered in cycle N+1 at the earliest.
- Wakeup: a CDB broadcast at edge N makes the entry eligible in cycle N+1.
- **Full with simultaneous free:** issue_ready reflects occupancy at the start of the cycle. A slot freed by ack at edge N is allocatable from cycle N+1 (no same-cycle reuse).
- **Simultaneous issue and ack:** count is unchanged; both updates take effect at the same edge.
- **CDB at issue:** the broadcast matching an issuing op's tag in that same cycle must not be lost (bypass above).
- dispatch_ack while dispatch_valid=0 is ignored.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_AND=4, OP_OR=5, OP_XOR=6;
  - the TAG_WIDTH default;
  - the RS entry field layout.
- Sub-module rs_prio_pick: a parameterised lowest-index-first one-hot picker. Instantiated twice: once for free-slot selection, once for ready-entry selection.

## Test plan
- **Basic ADD:** issue ADD, src1=5 and src2=7 both ready, dest_tag=3. Expect dispatch_valid=1 the next cycle with val1=5, val2=7, tag=3. With ack held high, the entry frees: count goes 1→0, empty=1.
- **Wakeup:** issue SUB with src1 waiting on tag 9, src2=2 ready. Then CDB tag=9 data=10. Expect dispatch the cycle after the broadcast, with val1=10, val2=2.
- **Issue-time bypass:** issue an op waiting on tags 4 and 4 in the same cycle as CDB tag=4 data=0xABCD. Expect both vals=0xABCD, dispatched the next cycle.
- **Full and backpressure:** fill NUM_ENTRIES=4 with ready ops while ack=0. Expect full=1, issue_ready=0, and the entry-0 payload offered and held. Pulse ack once. Expect count=3 and issue_ready=1 only the following cycle.
- **Priority:** entry 2 ready first, then entry 0 wakes while entry 2 is unacked. Expect the offer to switch to entry 0; ack releases entry 0 only.
- **Flush/reset mid-operation:** with 3 entries (1 waiting, 2 ready), assert flush together with issue_valid and ack. Expect count=0, dispatch_valid=0, and no entry allocated. Repeat the same setup with rst_n=0 and check all reset output values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types: opcodes, default tag width and the reservation-station entry layout.
package alu_pkg;
  localparam int RS_TAG_WIDTH = 6;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;

  typedef struct packed {
    logic                    rdy;
    logic [31:0]             val;
    logic [RS_TAG_WIDTH-1:0] tag;
  } rs_src_t;

  typedef struct packed {
    logic                    valid;
    logic [2:0]              op;
    logic [RS_TAG_WIDTH-1:0] dest_tag;
    rs_src_t                 src1;
    rs_src_t                 src2;
  } rs_entry_t;

  // A waiting source captures the CDB value when its producer tag is broadcast.
  function automatic rs_src_t src_snoop(rs_src_t s, logic cdb_v,
                                        logic [RS_TAG_WIDTH-1:0] cdb_t,
                                        logic [31:0] cdb_d);
    rs_src_t r;
    r = s;
    if (!s.rdy && cdb_v && (s.tag == cdb_t)) begin
      r.rdy = 1'b1;
      r.val = cdb_d;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_reservation_station_if.sv
// Issue, CDB, dispatch and status signals of the ALU reservation station.
interface alu_reservation_station_if #(
  parameter int TAG_WIDTH   = 6,
  parameter int NUM_ENTRIES = 4
);
  localparam int CW = $clog2(NUM_ENTRIES + 1);

  logic                 flush;
  logic                 issue_valid;
  logic                 issue_ready;
  logic [2:0]           issue_op;
  logic                 issue_src1_rdy, issue_src2_rdy;
  logic [31:0]          issue_src1_val, issue_src2_val;
  logic [TAG_WIDTH-1:0] issue_src1_tag, issue_src2_tag;
  logic [TAG_WIDTH-1:0] issue_dest_tag;
  logic                 cdb_valid;
  logic [TAG_WIDTH-1:0] cdb_tag;
  logic [31:0]          cdb_data;
  logic                 dispatch_valid;
  logic [2:0]           dispatch_op;
  logic [31:0]          dispatch_val1, dispatch_val2;
  logic [TAG_WIDTH-1:0] dispatch_tag;
  logic                 dispatch_ack;
  logic                 full, empty;
  logic [CW-1:0]        count;

  modport master (
    output flush, issue_valid, issue_op, issue_src1_rdy, issue_src2_rdy,
           issue_src1_val, issue_src2_val, issue_src1_tag, issue_src2_tag,
           issue_dest_tag, cdb_valid, cdb_tag, cdb_data, dispatch_ack,
    input  issue_ready, dispatch_valid, dispatch_op, dispatch_val1,
           dispatch_val2, dispatch_tag, full, empty, count
  );

  modport slave (
    input  flush, issue_valid, issue_op, issue_src1_rdy, issue_src2_rdy,
           issue_src1_val, issue_src2_val, issue_src1_tag, issue_src2_tag,
           issue_dest_tag, cdb_valid, cdb_tag, cdb_data, dispatch_ack,
    output issue_ready, dispatch_valid, dispatch_op, dispatch_val1,
           dispatch_val2, dispatch_tag, full, empty, count
  );
endinterface

// File: rtl/rs_prio_pick.sv
// Lowest-index-first one-hot picker.
module rs_prio_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         any_o
);
  // Two's-complement trick isolates the lowest set bit.
  assign gnt_o = req_i & (~req_i + N'(1));
  assign any_o = |req_i;
endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed ops until both operands arrive, then
// offers the lowest-index ready entry to the ALU.
module alu_reservation_station
  import alu_pkg::*;
#(
  parameter int TAG_WIDTH   = RS_TAG_WIDTH,
  parameter int NUM_ENTRIES = 4
) (
  input logic                      clk,
  input logic                      rst_n,
  alu_reservation_station_if.slave bus
);
  localparam int CW = $clog2(NUM_ENTRIES + 1);

  rs_entry_t              ent_q [NUM_ENTRIES];
  rs_entry_t              ent_d [NUM_ENTRIES];
  rs_entry_t              new_ent, sel_ent;
  logic [NUM_ENTRIES-1:0] vld, rdy, alloc_gnt, sel_gnt;
  logic                   free_any, sel_any, disp_v, do_issue, do_ack;
  logic [CW-1:0]          cnt;

  always_comb begin
    vld = '0;
    rdy = '0;
    cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      vld[i] = ent_q[i].valid;
      rdy[i] = ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
      cnt    = cnt + CW'(ent_q[i].valid);
    end
  end

  rs_prio_pick #(.N(NUM_ENTRIES)) u_free_pick (
    .req_i (~vld),
    .gnt_o (alloc_gnt),
    .any_o (free_any)
  );

  rs_prio_pick #(.N(NUM_ENTRIES)) u_sel_pick (
    .req_i (rdy),
    .gnt_o (sel_gnt),
    .any_o (sel_any)
  );

  assign disp_v   = sel_any && !bus.flush;
  assign do_issue = bus.issue_valid && free_any && !bus.flush;
  assign do_ack   = disp_v && bus.dispatch_ack;

  // Bypass a same-cycle CDB broadcast into the entry being allocated.
  always_comb begin
    new_ent          = '0;
    new_ent.valid    = 1'b1;
    new_ent.op       = bus.issue_op;
    new_ent.dest_tag = bus.issue_dest_tag;
    new_ent.src1     = src_snoop(rs_src_t'{bus.issue_src1_rdy, bus.issue_src1_val,
                                           bus.issue_src1_tag},
                                 bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    new_ent.src2     = src_snoop(rs_src_t'{bus.issue_src2_rdy, bus.issue_src2_val,
                                           bus.issue_src2_tag},
                                 bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid) begin
        ent_d[i].src1 = src_snoop(ent_q[i].src1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        ent_d[i].src2 = src_snoop(ent_q[i].src2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      end
      if (do_ack && sel_gnt[i])   ent_d[i].valid = 1'b0;
      if (do_issue && alloc_gnt[i]) ent_d[i] = new_ent;
      if (bus.flush)              ent_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!rst_n) ent_q[i] <= '0;
      else        ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (sel_gnt[i]) sel_ent = ent_q[i];
  end

  assign bus.dispatch_valid = disp_v;
  assign bus.dispatch_op    = disp_v ? sel_ent.op        : '0;
  assign bus.dispatch_val1  = disp_v ? sel_ent.src1.val  : '0;
  assign bus.dispatch_val2  = disp_v ? sel_ent.src2.val  : '0;
  assign bus.dispatch_tag   = disp_v ? TAG_WIDTH'(sel_ent.dest_tag) : '0;
  assign bus.issue_ready    = free_any;
  assign bus.full           = !free_any;
  assign bus.empty          = ~|vld;
  assign bus.count          = cnt;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench; expected dispatches go to a scoreboard checked by a negedge monitor.
module tb_alu_reservation_station;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_reservation_station_if #(.TAG_WIDTH(6), .NUM_ENTRIES(4)) bus ();

  alu_reservation_station #(.TAG_WIDTH(6), .NUM_ENTRIES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] v1, v2;
    logic [5:0]  tag;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [31:0] v1, input logic [31:0] v2,
                      input logic [5:0] tag);
    exp_t e;
    e.op = op; e.v1 = v1; e.v2 = v2; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic r1, input logic [31:0] v1,
                       input logic [5:0] t1, input logic r2, input logic [31:0] v2,
                       input logic [5:0] t2, input logic [5:0] dt);
    bus.issue_valid = 1'b1;
    bus.issue_op = op;
    bus.issue_src1_rdy = r1; bus.issue_src1_val = v1; bus.issue_src1_tag = t1;
    bus.issue_src2_rdy = r2; bus.issue_src2_val = v2; bus.issue_src2_tag = t2;
    bus.issue_dest_tag = dt;
  endtask

  // Scoreboard monitor: compares whatever the ALU consumes against the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!bus.dispatch_valid) begin
        chk("disp_zero", bus.dispatch_val1 | bus.dispatch_val2 |
            {26'd0, bus.dispatch_tag} | {29'd0, bus.dispatch_op}, 32'd0);
      end else if (bus.dispatch_ack && !bus.flush) begin
        if (q.size() == 0) begin
          chk("sb_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_op",   {29'd0, bus.dispatch_op},  {29'd0, e.op});
          chk("sb_val1", bus.dispatch_val1,         e.v1);
          chk("sb_val2", bus.dispatch_val2,         e.v2);
          chk("sb_tag",  {26'd0, bus.dispatch_tag}, {26'd0, e.tag});
        end
      end
    end
  end

  initial begin
    bus.flush = 0; bus.issue_valid = 0; bus.issue_op = '0;
    bus.issue_src1_rdy = 0; bus.issue_src2_rdy = 0;
    bus.issue_src1_val = '0; bus.issue_src2_val = '0;
    bus.issue_src1_tag = '0; bus.issue_src2_tag = '0; bus.issue_dest_tag = '0;
    bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_data = '0; bus.dispatch_ack = 0;
    step(); step();
    rst_n = 1'b1;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_ready", 32'(bus.issue_ready), 1);
    chk("rst_dv", 32'(bus.dispatch_valid), 0);

    // Basic ADD
    issue(OP_ADD, 1, 5, 0, 1, 7, 0, 3);
    push(OP_ADD, 5, 7, 3);
    step(); bus.issue_valid = 0;
    chk("add_dv", 32'(bus.dispatch_valid), 1);
    chk("add_count", 32'(bus.count), 1);
    chk("add_val1", bus.dispatch_val1, 5);
    bus.dispatch_ack = 1;
    step(); bus.dispatch_ack = 0;
    chk("add_count0", 32'(bus.count), 0);
    chk("add_empty", 32'(bus.empty), 1);

    // Wakeup from CDB
    issue(OP_SUB, 0, 0, 9, 1, 2, 0, 10);
    step(); bus.issue_valid = 0;
    chk("wk_wait", 32'(bus.dispatch_valid), 0);
    bus.cdb_valid = 1; bus.cdb_tag = 9; bus.cdb_data = 10;
    step(); bus.cdb_valid = 0;
    chk("wk_dv", 32'(bus.dispatch_valid), 1);
    push(OP_SUB, 10, 2, 10);
    bus.dispatch_ack = 1;
    step(); bus.dispatch_ack = 0;
    chk("wk_empty", 32'(bus.empty), 1);

    // Issue-time bypass on both sources
    issue(OP_XOR, 0, 0, 4, 0, 0, 4, 5);
    bus.cdb_valid = 1; bus.cdb_tag = 4; bus.cdb_data = 32'hABCD;
    step(); bus.issue_valid = 0; bus.cdb_valid = 0;
    chk("byp_dv", 32'(bus.dispatch_valid), 1);
    push(OP_XOR, 32'hABCD, 32'hABCD, 5);
    bus.dispatch_ack = 1;
    step(); bus.dispatch_ack = 0;
    chk("byp_empty", 32'(bus.empty), 1);

    // Full and backpressure
    issue(OP_AND, 1, 1, 0, 1, 2, 0, 20); step();
    issue(OP_OR,  1, 3, 0, 1, 4, 0, 21); step();
    issue(OP_ADD, 1, 5, 0, 1, 6, 0, 22); step();
    issue(OP_SUB, 1, 7, 0, 1, 8, 0, 23); step();
    chk("full_full", 32'(bus.full), 1);
    chk("full_ready", 32'(bus.issue_ready), 0);
    chk("full_count", 32'(bus.count), 4);
    chk("full_tag", 32'(bus.dispatch_tag), 20);
    issue(OP_ADD, 1, 9, 0, 1, 9, 0, 24);
    step();
    chk("full_hold_count", 32'(bus.count), 4);
    chk("full_hold_tag", 32'(bus.dispatch_tag), 20);
    push(OP_AND, 1, 2, 20);
    bus.dispatch_ack = 1;
    step(); bus.dispatch_ack = 0;
    chk("free_count", 32'(bus.count), 3);
    chk("free_ready", 32'(bus.issue_ready), 1);
    step(); bus.issue_valid = 0;
    chk("refill_count", 32'(bus.count), 4);
    chk("refill_tag", 32'(bus.dispatch_tag), 24);
    push(OP_ADD, 9, 9, 24);
    push(OP_OR, 3, 4, 21);
    push(OP_ADD, 5, 6, 22);
    push(OP_SUB, 7, 8, 23);
    bus.dispatch_ack = 1;
    repeat (4) step();
    bus.dispatch_ack = 0;
    chk("drain_empty", 32'(bus.empty), 1);

    // Priority re-selection
    issue(OP_ADD, 0, 0, 30, 1, 100, 0, 40); step();
    issue(OP_SUB, 0, 0, 31, 1, 5, 0, 41); step();
    issue(OP_AND, 1, 11, 0, 1, 22, 0, 42); step();
    bus.issue_valid = 0;
    chk("prio_e2", 32'(bus.dispatch_tag), 42);
    bus.cdb_valid = 1; bus.cdb_tag = 30; bus.cdb_data = 50;
    step(); bus.cdb_valid = 0;
    chk("prio_e0", 32'(bus.dispatch_tag), 40);
    push(OP_ADD, 50, 100, 40);
    bus.dispatch_ack = 1;
    step(); bus.dispatch_ack = 0;
    chk("prio_count", 32'(bus.count), 2);
    chk("prio_back_e2", 32'(bus.dispatch_tag), 42);
    chk("prio_back_val1", bus.dispatch_val1, 11);

    // Flush with concurrent issue and ack
    issue(OP_OR, 1, 32'hF0, 0, 1, 32'h0F, 0, 43); step();
    chk("fl_setup_count", 32'(bus.count), 3);
    chk("fl_setup_tag", 32'(bus.dispatch_tag), 43);
    issue(OP_ADD, 1, 1, 0, 1, 1, 0, 50);
    bus.flush = 1; bus.dispatch_ack = 1;
    #1;
    chk("fl_dv_forced", 32'(bus.dispatch_valid), 0);
    step();
    bus.flush = 0; bus.dispatch_ack = 0; bus.issue_valid = 0;
    chk("fl_count", 32'(bus.count), 0);
    chk("fl_empty", 32'(bus.empty), 1);
    chk("fl_dv", 32'(bus.dispatch_valid), 0);
    step();
    chk("fl_no_alloc", 32'(bus.count), 0);

    // Reset mid-operation
    issue(OP_ADD, 0, 0, 50, 1, 1, 0, 44); step();
    issue(OP_SUB, 1, 3, 0, 1, 1, 0, 45); step();
    issue(OP_XOR, 1, 7, 0, 1, 7, 0, 46); step();
    bus.issue_valid = 0;
    chk("rs_setup_count", 32'(bus.count), 3);
    chk("rs_setup_tag", 32'(bus.dispatch_tag), 45);
    issue(OP_ADD, 1, 2, 0, 1, 2, 0, 47);
    rst_n = 0; bus.dispatch_ack = 1;
    step();
    rst_n = 1; bus.dispatch_ack = 0; bus.issue_valid = 0;
    chk("rs_count", 32'(bus.count), 0);
    chk("rs_empty", 32'(bus.empty), 1);
    chk("rs_full", 32'(bus.full), 0);
    chk("rs_ready", 32'(bus.issue_ready), 1);
    chk("rs_dv", 32'(bus.dispatch_valid), 0);
    chk("rs_dop", 32'(bus.dispatch_op), 0);
    chk("rs_dval", bus.dispatch_val1 | bus.dispatch_val2, 0);
    chk("rs_dtag", 32'(bus.dispatch_tag), 0);
    step();
    chk("rs_stay", 32'(bus.count), 0);
    chk("sb_drain", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
